// File: rtl/iceboard_status_pkg.sv
// Shared constants, frame layout and receiver state encoding for the iceboard
// status frame receiver.
package iceboard_status_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'h55;
  localparam int         PAYLOAD_LEN = 14;
  localparam int         FRAME_LEN   = 17;
  localparam int         SHADOW_W    = PAYLOAD_LEN * 8;

  localparam int POS_OFF  = 0;
  localparam int VEL_OFF  = 4;
  localparam int DISP_OFF = 8;
  localparam int CUR_OFF  = 12;

  typedef enum logic [1:0] {HUNT, ID, PAYLOAD, CHECK} rx_state_e;

  // The shadow buffer shifts in at the LSB end, so payload byte 0 ends up in
  // the top byte once all PAYLOAD_LEN bytes have arrived.
  function automatic logic [31:0] field32(input logic [SHADOW_W-1:0] shadow,
                                          input int off);
    return shadow[(PAYLOAD_LEN-off-4)*8 +: 32];
  endfunction

  function automatic logic [15:0] field16(input logic [SHADOW_W-1:0] shadow,
                                          input int off);
    return shadow[(PAYLOAD_LEN-off-2)*8 +: 16];
  endfunction

endpackage

// File: rtl/status_rx_timeout.sv
// Inter-byte idle counter: pulses timeout_o when the receiver has been inside a
// frame for TIMEOUT_CYCLES clocks without a byte.
module status_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 13_020
) (
  input  logic clock,
  input  logic reset,
  input  logic active_i,
  input  logic activity_i,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A byte arriving on the limit cycle wins over the timeout.
  assign timeout_o = active_i && !activity_i &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!active_i || activity_i || timeout_o) cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/iceboard_status_rx.sv
// Parses 17-byte iceboard status frames into per-motor status registers.
// Define ICEBOARD_STATUS_RX_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES.
module iceboard_status_rx
  import iceboard_status_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int TIMEOUT_CYCLES   = 13_020
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic signed [31:0] position     [NUMBER_OF_MOTORS],
  output logic signed [31:0] velocity     [NUMBER_OF_MOTORS],
  output logic signed [31:0] displacement [NUMBER_OF_MOTORS],
  output logic signed [15:0] current      [NUMBER_OF_MOTORS],
  output logic               update_strobe,
  output logic [7:0]         update_motor,
  output logic [15:0]        frame_ok_count,
  output logic [15:0]        frame_err_count
);

  rx_state_e             state_q, state_d;
  logic [7:0]            id_q, id_d;
  logic [7:0]            sum_q, sum_d;
  logic [3:0]            idx_q, idx_d;
  logic [SHADOW_W-1:0]   shadow_q, shadow_d;
  logic signed [31:0]    position_q     [NUMBER_OF_MOTORS];
  logic signed [31:0]    velocity_q     [NUMBER_OF_MOTORS];
  logic signed [31:0]    displacement_q [NUMBER_OF_MOTORS];
  logic signed [15:0]    current_q      [NUMBER_OF_MOTORS];
  logic                  strobe_q;
  logic [7:0]            motor_q;
  logic [15:0]           ok_q, err_q;
  logic                  commit, reject, timeout, id_ok, sum_ok;

  assign id_ok  = (int'(id_q) < NUMBER_OF_MOTORS);
  assign sum_ok = (sum_q == rx_data);

`ifdef ICEBOARD_STATUS_RX_TIMEOUT_EN
  status_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .active_i   (state_q != HUNT),
    .activity_i (rx_valid),
    .timeout_o  (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    commit   = 1'b0;
    reject   = 1'b0;
    if (timeout) begin
      state_d = HUNT;
      reject  = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        HUNT: if (rx_data == SYNC_BYTE) state_d = ID;
        ID: begin
          id_d    = rx_data;
          sum_d   = rx_data;
          idx_d   = 4'd0;
          state_d = PAYLOAD;
        end
        // Sync bytes are plain data here; only the byte count ends the payload.
        PAYLOAD: begin
          shadow_d = {shadow_q[SHADOW_W-9:0], rx_data};
          sum_d    = sum_q + rx_data;
          idx_d    = idx_q + 4'd1;
          if (idx_q == 4'(PAYLOAD_LEN - 1)) state_d = CHECK;
        end
        CHECK: begin
          commit  = sum_ok && id_ok;
          reject  = !(sum_ok && id_ok);
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= HUNT;
      id_q     <= '0;
      sum_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      strobe_q <= 1'b0;
      motor_q  <= '0;
      ok_q     <= '0;
      err_q    <= '0;
      for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
        position_q[m]     <= '0;
        velocity_q[m]     <= '0;
        displacement_q[m] <= '0;
        current_q[m]      <= '0;
      end
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      sum_q    <= sum_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      strobe_q <= commit;
      if (commit) motor_q <= id_q;
      if (commit) ok_q    <= ok_q + 16'd1;
      if (reject) err_q   <= err_q + 16'd1;
      for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
        if (commit && id_q == 8'(m)) begin
          position_q[m]     <= field32(shadow_q, POS_OFF);
          velocity_q[m]     <= field32(shadow_q, VEL_OFF);
          displacement_q[m] <= field32(shadow_q, DISP_OFF);
          current_q[m]      <= field16(shadow_q, CUR_OFF);
        end
      end
    end
  end

  assign position        = position_q;
  assign velocity        = velocity_q;
  assign displacement    = displacement_q;
  assign current         = current_q;
  assign update_strobe   = strobe_q;
  assign update_motor    = motor_q;
  assign frame_ok_count  = ok_q;
  assign frame_err_count = err_q;

endmodule
